multicycle_ctrl: RTL and testbench

Control FSM for the multicycle LEGv8 datapath. It sequences fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one unified memory port. It supports the same instruction subset as the single-cycle main decoder: ADD, SUB, AND, ORR, LDUR, STUR and CBZ. It also stretches memory states on a ready handshake, counts retired instructions, and traps on illegal opcodes.

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle LEGv8 controller and its datapath.
// The controller takes the master side: it reads Op/Zero/MemReady and
// drives every enable, mux select and status output.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      Op;
  logic             Zero;
  logic             MemReady;
  logic             PCEn;
  logic             PCSrc;
  logic             IorD;
  logic             IRWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             Reg2Loc;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             Illegal;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Op, Zero, MemReady,
    output PCEn, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
           RegWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, Illegal, State,
           InstrCount
  );

  modport slave (
    output Op, Zero, MemReady,
    input  PCEn, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
           RegWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, Illegal, State,
           InstrCount
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences one shared ALU and one unified
// memory port over fetch/decode/execute/memory/write-back, stretches memory
// states on MemReady, counts retired instructions and traps on bad opcodes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | read instruction at PC, PC+4 into PC on MemReady
// DECODE  | read registers, branch target into ALUOut, dispatch on Op
// EXEC_R  | R-type ALU operation on A and B
// R_WB    | write ALUOut to Rd, retire
// ADDR_LD | LDUR address = A + imm
// MEM_RD  | load data read, held until MemReady
// MEM_WB  | write MDR to Rt, retire
// ADDR_ST | STUR address = A + imm
// MEM_WR  | store data write, held until MemReady, retires on ready
// BRANCH  | CBZ: pass B through ALU, load target into PC if Zero, retire
// ERROR   | illegal opcode trap, absorbing until reset
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    R_WB    = 4'd3,
    ADDR_LD = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WB  = 4'd6,
    ADDR_ST = 4'd7,
    MEM_WR  = 4'd8,
    BRANCH  = 4'd9,
    ERROR   = 4'd10
  } state_e;

  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;   // low three bits are don't-care

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             is_rtype, is_ldur, is_stur, is_cbz;

  // Opcode classification; only consumed while in DECODE.
  always_comb begin
    is_rtype = (bus.Op == OP_ADD) || (bus.Op == OP_SUB) ||
               (bus.Op == OP_AND) || (bus.Op == OP_ORR);
    is_ldur  = (bus.Op == OP_LDUR);
    is_stur  = (bus.Op == OP_STUR);
    is_cbz   = (bus.Op[10:3] == OP_CBZ);
  end

  // Next-state, retire detection and counter update.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH:   if (bus.MemReady) state_d = DECODE;
      DECODE: begin
        if (is_rtype)     state_d = EXEC_R;
        else if (is_ldur) state_d = ADDR_LD;
        else if (is_stur) state_d = ADDR_ST;
        else if (is_cbz)  state_d = BRANCH;
        else              state_d = ERROR;
      end
      EXEC_R:  state_d = R_WB;
      R_WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      ADDR_LD: state_d = MEM_RD;
      MEM_RD:  if (bus.MemReady) state_d = MEM_WB;
      MEM_WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      ADDR_ST: state_d = MEM_WR;
      MEM_WR: begin
        if (bus.MemReady) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // State and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-state control decode; everything reads 0 while reset is held.
  always_comb begin
    bus.PCEn       = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.IorD       = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.Reg2Loc    = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.Illegal    = 1'b0;
    bus.State      = 4'd0;
    bus.InstrCount = '0;
    if (!reset) begin
      bus.State      = state_q;
      bus.InstrCount = cnt_q;
      case (state_q)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.MemReady;
          bus.PCEn    = bus.MemReady;
        end
        DECODE: begin
          bus.ALUSrcB = 2'b11;
          bus.Reg2Loc = is_stur || is_cbz;
        end
        EXEC_R: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        R_WB:    bus.RegWrite = 1'b1;
        ADDR_LD: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        MEM_RD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        MEM_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        ADDR_ST: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          bus.Reg2Loc = 1'b1;
        end
        MEM_WR: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
          bus.Reg2Loc  = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b01;
          bus.Reg2Loc = 1'b1;
          bus.PCSrc   = 1'b1;
          bus.PCEn    = bus.Zero;
        end
        ERROR:   bus.Illegal = 1'b1;
        default: bus.Illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a table of hand-written instruction traces,
// randomized instruction streams expanded into expected state sequences,
// and directed reset / illegal-opcode / counter-wrap sequences.
module tb_multicycle_ctrl;

  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_CBZ  = 11'b101_1010_0101;

  logic        clk = 1'b0;
  logic        rst32 = 1'b1;
  logic        rst4  = 1'b1;
  logic        sel4  = 1'b0;
  logic [10:0] op_drv = '0;
  logic        zero_drv = 1'b0;
  logic        rdy_drv  = 1'b0;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] model_cnt = '0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus32 ();
  multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

  multicycle_ctrl #(.CNT_W(32)) dut32 (.clk(clk), .reset(rst32), .bus(bus32));
  multicycle_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .reset(rst4),  .bus(bus4));

  assign bus32.Op       = op_drv;
  assign bus32.Zero     = zero_drv;
  assign bus32.MemReady = rdy_drv;
  assign bus4.Op        = op_drv;
  assign bus4.Zero      = zero_drv;
  assign bus4.MemReady  = rdy_drv;

  logic [18:0] act32, act4, act;
  logic [31:0] act_cnt;
  assign act32 = {bus32.PCEn, bus32.PCSrc, bus32.IorD, bus32.IRWrite, bus32.MemRead,
                  bus32.MemWrite, bus32.MemtoReg, bus32.RegWrite, bus32.Reg2Loc,
                  bus32.ALUSrcA, bus32.ALUSrcB, bus32.ALUOp, bus32.Illegal, bus32.State};
  assign act4  = {bus4.PCEn, bus4.PCSrc, bus4.IorD, bus4.IRWrite, bus4.MemRead,
                  bus4.MemWrite, bus4.MemtoReg, bus4.RegWrite, bus4.Reg2Loc,
                  bus4.ALUSrcA, bus4.ALUSrcB, bus4.ALUOp, bus4.Illegal, bus4.State};
  always_comb begin
    act     = sel4 ? act4 : act32;
    act_cnt = sel4 ? {28'd0, bus4.InstrCount} : bus32.InstrCount;
  end

  // Expected outputs for a state, straight from the per-state output list.
  function automatic logic [18:0] exp_out(input logic rst, input logic [3:0] st,
                                          input logic mr, input logic z,
                                          input logic [10:0] op);
    logic pcen, pcsrc, iord, irw, mrd, mwr, m2r, rw, r2l, asa, ill;
    logic [1:0] asb, aop;
    logic [3:0] st_o;
    {pcen, pcsrc, iord, irw, mrd, mwr, m2r, rw, r2l, asa, ill} = '0;
    asb  = 2'b00;
    aop  = 2'b00;
    st_o = 4'd0;
    if (!rst) begin
      st_o = st;
      case (st)
        4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pcen = mr; end
        4'd1: begin asb = 2'b11; r2l = (op == OP_STUR) || (op[10:3] == 8'b1011_0100); end
        4'd2: begin asa = 1; aop = 2'b10; end
        4'd3: rw = 1;
        4'd4: begin asa = 1; asb = 2'b10; end
        4'd5: begin iord = 1; mrd = 1; end
        4'd6: begin rw = 1; m2r = 1; end
        4'd7: begin asa = 1; asb = 2'b10; r2l = 1; end
        4'd8: begin iord = 1; mwr = 1; r2l = 1; end
        4'd9: begin asa = 1; aop = 2'b01; r2l = 1; pcsrc = 1; pcen = z; end
        default: ill = 1;
      endcase
    end
    return {pcen, pcsrc, iord, irw, mrd, mwr, m2r, rw, r2l, asa, asb, aop, ill, st_o};
  endfunction

  // One clock: drive inputs, compare on the falling edge, advance past the rising edge.
  task automatic step(input string name, input logic [3:0] st, input logic mr,
                      input logic z, input logic [10:0] op);
    logic        rst_now;
    logic [18:0] e;
    logic [31:0] ec;
    op_drv   = op;
    zero_drv = z;
    rdy_drv  = mr;
    @(negedge clk);
    rst_now = sel4 ? rst4 : rst32;
    e  = exp_out(rst_now, st, mr, z, op);
    ec = rst_now ? 32'd0 : (sel4 ? (model_cnt & 32'hF) : model_cnt);
    n_vec++;
    if (act !== e || act_cnt !== ec) begin
      n_miss++;
      $display("FAIL %s: outputs=%h count=%0d, expected outputs=%h count=%0d",
               name, act, act_cnt, e, ec);
    end
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: expand one instruction into its expected trace.
  logic [3:0]  st_q[$];
  logic        mr_q[$];

  task automatic build(input int cls, input int fw, input int mw);
    st_q.delete();
    mr_q.delete();
    for (int i = 0; i < fw; i++) begin st_q.push_back(4'd0); mr_q.push_back(1'b0); end
    st_q.push_back(4'd0); mr_q.push_back(1'b1);
    st_q.push_back(4'd1); mr_q.push_back(1'($urandom_range(0, 1)));
    case (cls)
      0: begin
        st_q.push_back(4'd2); mr_q.push_back(1'($urandom_range(0, 1)));
        st_q.push_back(4'd3); mr_q.push_back(1'($urandom_range(0, 1)));
      end
      1: begin
        st_q.push_back(4'd4); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin st_q.push_back(4'd5); mr_q.push_back(1'b0); end
        st_q.push_back(4'd5); mr_q.push_back(1'b1);
        st_q.push_back(4'd6); mr_q.push_back(1'($urandom_range(0, 1)));
      end
      2: begin
        st_q.push_back(4'd7); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin st_q.push_back(4'd8); mr_q.push_back(1'b0); end
        st_q.push_back(4'd8); mr_q.push_back(1'b1);
      end
      default: begin
        st_q.push_back(4'd9); mr_q.push_back(1'($urandom_range(0, 1)));
      end
    endcase
  endtask

  task automatic run_instr(input string name, input logic [10:0] op, input logic z);
    for (int i = 0; i < st_q.size(); i++) begin
      step(name, st_q[i], mr_q[i], (st_q[i] == 4'd9) ? z : 1'($urandom_range(0, 1)),
           (st_q[i] == 4'd0) ? 11'($urandom) : op);
    end
    model_cnt++;
  endtask

  typedef struct {
    logic [10:0] op;
    logic        zero;
    logic [7:0]  rdy;
    int          len;
    logic [31:0] states;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [10:0] rop;
    int          cls;
    logic [10:0] rtab[4];

    // Hand-written traces: state nibble j and MemReady bit j belong to cycle j.
    vecs[0] = '{OP_ADD,  1'b0, 8'b1111_1111, 4, 32'h0000_3210};
    vecs[1] = '{OP_SUB,  1'b0, 8'b1111_1110, 5, 32'h0003_2100};
    vecs[2] = '{OP_AND,  1'b0, 8'b1111_1111, 4, 32'h0000_3210};
    vecs[3] = '{OP_ORR,  1'b1, 8'b1111_1111, 4, 32'h0000_3210};
    vecs[4] = '{OP_LDUR, 1'b0, 8'b0110_0001, 7, 32'h0655_5410};
    vecs[5] = '{OP_STUR, 1'b0, 8'b1111_1111, 4, 32'h0000_8710};
    vecs[6] = '{OP_STUR, 1'b1, 8'b1111_0111, 5, 32'h0008_8710};
    vecs[7] = '{OP_CBZ,  1'b1, 8'b1111_1111, 3, 32'h0000_0910};
    vecs[8] = '{OP_CBZ,  1'b0, 8'b1111_1111, 3, 32'h0000_0910};
    vecs[9] = '{OP_LDUR, 1'b1, 8'b1111_1100, 7, 32'h0654_1000};
    rtab[0] = OP_ADD; rtab[1] = OP_SUB; rtab[2] = OP_AND; rtab[3] = OP_ORR;

    #1;
    // Reset held two cycles: everything reads 0.
    step("reset_0", 4'd0, 1'b1, 1'b1, OP_ADD);
    step("reset_1", 4'd0, 1'b1, 1'b1, OP_ADD);
    rst32 = 1'b0;
    model_cnt = '0;
    step("first_fetch", 4'd0, 1'b0, 1'b0, '0);

    foreach (vecs[k]) begin
      for (int j = 0; j < vecs[k].len; j++)
        step($sformatf("vec%0d_cyc%0d", k, j), vecs[k].states[4*j +: 4],
             vecs[k].rdy[j], vecs[k].zero, vecs[k].op);
      model_cnt++;
    end

    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0:       rop = rtab[$urandom_range(0, 3)];
        1:       rop = OP_LDUR;
        2:       rop = OP_STUR;
        default: rop = {8'b1011_0100, 3'($urandom)};
      endcase
      build(cls, $urandom_range(0, 2), $urandom_range(0, 2));
      run_instr($sformatf("rand%0d", n), rop, 1'($urandom_range(0, 1)));
    end

    // Reset during a load wait: aborted, count cleared, back to FETCH.
    step("ldabort_f", 4'd0, 1'b1, 1'b0, OP_LDUR);
    step("ldabort_d", 4'd1, 1'b1, 1'b0, OP_LDUR);
    step("ldabort_a", 4'd4, 1'b1, 1'b0, OP_LDUR);
    step("ldabort_w0", 4'd5, 1'b0, 1'b0, OP_LDUR);
    step("ldabort_w1", 4'd5, 1'b0, 1'b0, OP_LDUR);
    rst32 = 1'b1;
    step("ldabort_rst", 4'd5, 1'b1, 1'b0, OP_LDUR);
    rst32 = 1'b0;
    model_cnt = '0;
    step("ldabort_fetch", 4'd0, 1'b0, 1'b0, OP_LDUR);

    // Illegal opcode: trap absorbs for 20 cycles regardless of inputs.
    step("ill_f", 4'd0, 1'b1, 1'b0, 11'd0);
    step("ill_d", 4'd1, 1'b1, 1'b0, 11'd0);
    for (int i = 0; i < 20; i++)
      step($sformatf("ill_err%0d", i), 4'd10, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 11'($urandom));
    rst32 = 1'b1;
    step("ill_rst", 4'd10, 1'b1, 1'b1, 11'd0);
    rst32 = 1'b0;
    model_cnt = '0;
    step("ill_recover", 4'd0, 1'b1, 1'b0, 11'd0);
    step("ill_recover_d", 4'd1, 1'b1, 1'b0, OP_CBZ);

    // 4-bit counter instance: 16 stores wrap the count 15 -> 0.
    sel4 = 1'b1;
    step("w4_reset", 4'd0, 1'b1, 1'b0, OP_STUR);
    rst4 = 1'b0;
    model_cnt = '0;
    for (int n = 0; n < 16; n++) begin
      build(2, $urandom_range(0, 1), $urandom_range(0, 1));
      run_instr($sformatf("w4_stur%0d", n), OP_STUR, 1'b0);
    end
    // Reset while MEM_WR waits, with MemReady arriving on the reset edge: no retire.
    step("w4_f", 4'd0, 1'b1, 1'b0, OP_STUR);
    step("w4_d", 4'd1, 1'b1, 1'b0, OP_STUR);
    step("w4_a", 4'd7, 1'b1, 1'b0, OP_STUR);
    step("w4_wait", 4'd8, 1'b0, 1'b0, OP_STUR);
    rst4 = 1'b1;
    step("w4_rst", 4'd8, 1'b1, 1'b0, OP_STUR);
    rst4 = 1'b0;
    model_cnt = '0;
    step("w4_after", 4'd0, 1'b1, 1'b0, OP_STUR);
    step("w4_after_d", 4'd1, 1'b1, 1'b0, OP_STUR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
